l2_request_responder: RTL and testbench

- L2-side responder for the split L1 cache's miss traffic.
- Accepts L1 requests (data read, data write-through, instruction fetch), returns a block-aligned response after a fixed per-op latency, and keeps request statistics.
- Also forwards L2-originated evict (back-invalidate) commands to L1 so L2 stays inclusive.
- Sits between the L1 cache and the L2 array/controller; one request outstanding at a time.

---
 rtl/l2_request_responder.sv | 140 ++++++++++++++
 tb/tb_l2_request_responder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_responder.sv
// L2-side responder for L1 miss traffic: one outstanding request answered after a
// fixed per-op latency, plus a single-entry back-invalidate (evict) buffer toward L1.
module l2_request_responder #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int BYTE_SELECT_WIDTH = 6,
  parameter int READ_LATENCY      = 4,
  parameter int WRITE_LATENCY     = 2,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [1:0]               resp_op,
  output logic [ADDRESS_WIDTH-1:0] resp_addr,
  input  logic                     evict_in_valid,
  output logic                     evict_in_ready,
  input  logic [ADDRESS_WIDTH-1:0] evict_in_addr,
  output logic                     evict_valid,
  input  logic                     evict_ready,
  output logic [ADDRESS_WIDTH-1:0] evict_addr,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     read_count,
  output logic [CNT_WIDTH-1:0]     write_count,
  output logic [CNT_WIDTH-1:0]     evict_count
);

  localparam int BLOCK_W = ADDRESS_WIDTH - BYTE_SELECT_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] BLOCK_MASK =
    {{BLOCK_W{1'b1}}, {BYTE_SELECT_WIDTH{1'b0}}};

  localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_IFETCH = 2'd2;

  logic [1:0] state;
  logic [7:0] cnt;
  logic [7:0] load_cnt;
  logic       pending;
  logic       hazard;
  logic       req_fire;
  logic       resp_fire;
  logic       evict_in_fire;
  logic       evict_fire;
  logic       req_is_read;
  logic       req_is_write;

  function automatic logic [ADDRESS_WIDTH-1:0] block_align(input logic [ADDRESS_WIDTH-1:0] a);
    return a & BLOCK_MASK;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // A request to a block still being back-invalidated must wait for the evict to land in L1
  assign hazard = pending &&
    (req_addr[ADDRESS_WIDTH-1:BYTE_SELECT_WIDTH] == evict_addr[ADDRESS_WIDTH-1:BYTE_SELECT_WIDTH]);

  assign req_ready      = !rst && (state == ST_IDLE) && !hazard;
  assign resp_valid     = (state == ST_RESP);
  assign busy           = (state != ST_IDLE);
  assign evict_valid    = pending;
  assign evict_in_ready = !pending;

  assign req_fire      = req_valid && req_ready;
  assign resp_fire     = resp_valid && resp_ready;
  assign evict_in_fire = evict_in_valid && evict_in_ready;
  assign evict_fire    = evict_valid && evict_ready;

  assign req_is_read  = (req_op == OP_READ) || (req_op == OP_IFETCH);
  assign req_is_write = (req_op == OP_WRITE);
  assign load_cnt     = req_is_write ? WR_LOAD : RD_LOAD;

  // Request FSM: illegal ops complete the handshake but never leave IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      resp_op   <= '0;
      resp_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire && (req_is_read || req_is_write)) begin
            resp_op   <= req_op;
            resp_addr <= block_align(req_addr);
            cnt       <= load_cnt;
            state     <= (load_cnt == 8'd0) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_fire) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_count  <= '0;
      write_count <= '0;
      evict_count <= '0;
    end else begin
      if (req_fire && req_is_read)  read_count  <= sat_inc(read_count);
      if (req_fire && req_is_write) write_count <= sat_inc(write_count);
      if (evict_fire)               evict_count <= sat_inc(evict_count);
    end
  end

  // Evict buffer: ready only when empty, so fill and drain never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      evict_addr <= '0;
    end else if (evict_fire) begin
      pending <= 1'b0;
    end else if (evict_in_fire) begin
      pending    <= 1'b1;
      evict_addr <= block_align(evict_in_addr);
    end
  end

endmodule

// File: tb/tb_l2_request_responder.sv
// Bench for l2_request_responder: vector table through a response scoreboard, hand-written
// stall/hazard/reset sequences, and a narrow-counter instance for saturation.
module tb_l2_request_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_op;
  logic [31:0] resp_addr;
  logic        evict_in_valid, evict_in_ready;
  logic [31:0] evict_in_addr;
  logic        evict_valid, evict_ready;
  logic [31:0] evict_addr;
  logic        busy;
  logic [15:0] read_count, write_count, evict_count;

  logic        s_req_valid, s_req_ready;
  logic [1:0]  s_req_op;
  logic [31:0] s_req_addr;
  logic        s_resp_valid, s_resp_ready;
  logic [1:0]  s_resp_op;
  logic [31:0] s_resp_addr;
  logic        s_evict_in_valid, s_evict_in_ready;
  logic [31:0] s_evict_in_addr;
  logic        s_evict_valid, s_evict_ready;
  logic [31:0] s_evict_addr;
  logic        s_busy;
  logic [2:0]  s_read_count, s_write_count, s_evict_count;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] exp_addr;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          lat;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_reads, exp_writes, m;

  always #5 clk = ~clk;

  l2_request_responder u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op), .resp_addr(resp_addr),
    .evict_in_valid(evict_in_valid), .evict_in_ready(evict_in_ready), .evict_in_addr(evict_in_addr),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_addr(evict_addr),
    .busy(busy), .read_count(read_count), .write_count(write_count), .evict_count(evict_count)
  );

  l2_request_responder #(.READ_LATENCY(1), .WRITE_LATENCY(1), .CNT_WIDTH(3)) u_sat (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(s_req_op), .req_addr(s_req_addr),
    .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_op(s_resp_op), .resp_addr(s_resp_addr),
    .evict_in_valid(s_evict_in_valid), .evict_in_ready(s_evict_in_ready), .evict_in_addr(s_evict_in_addr),
    .evict_valid(s_evict_valid), .evict_ready(s_evict_ready), .evict_addr(s_evict_addr),
    .busy(s_busy), .read_count(s_read_count), .write_count(s_write_count), .evict_count(s_evict_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  // Caller sits on the negedge right after the accept edge.
  task automatic wait_resp();
    int   k;
    exp_t e;
    k = 1;
    #1;
    while (!resp_valid && k < 300) begin
      @(negedge clk); #1; k++;
    end
    chk("resp_valid", 32'(resp_valid), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_op", 32'(resp_op), 32'(e.op));
      chk("resp_addr", resp_addr, e.addr);
      chk("resp_latency", 32'(k), 32'(e.lat));
    end
  endtask

  task automatic txn(input logic [1:0] op, input logic [31:0] addr,
                     input logic [31:0] exp_addr, input int lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    #1;
    chk("req_ready", 32'(req_ready), 1);
    sb.push_back('{op: op, addr: exp_addr, lat: lat});
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{op: 2'd0, addr: 32'h1234_5678, exp_addr: 32'h1234_5640, lat: 4};
    vecs[1] = '{op: 2'd1, addr: 32'h0000_00FF, exp_addr: 32'h0000_00C0, lat: 2};
    vecs[2] = '{op: 2'd2, addr: 32'hABCD_0040, exp_addr: 32'hABCD_0040, lat: 4};
    vecs[3] = '{op: 2'd0, addr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFC0, lat: 4};
    vecs[4] = '{op: 2'd1, addr: 32'h8000_003F, exp_addr: 32'h8000_0000, lat: 2};
    vecs[5] = '{op: 2'd2, addr: 32'h0000_0000, exp_addr: 32'h0000_0000, lat: 4};

    rst = 1'b1;
    req_valid = 1'b0; req_op = 2'd0; req_addr = '0; resp_ready = 1'b1;
    evict_in_valid = 1'b0; evict_in_addr = '0; evict_ready = 1'b0;
    s_req_valid = 1'b0; s_req_op = 2'd0; s_req_addr = 32'h100; s_resp_ready = 1'b1;
    s_evict_in_valid = 1'b0; s_evict_in_addr = 32'h200; s_evict_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_op", 32'(resp_op), 0);
    chk("rst_resp_addr", resp_addr, 0);
    chk("rst_evict_valid", 32'(evict_valid), 0);
    chk("rst_evict_addr", evict_addr, 0);
    chk("rst_evict_in_ready", 32'(evict_in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_counts", {read_count, write_count} | 32'(evict_count), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 1);

    exp_reads = 0; exp_writes = 0;
    for (int i = 0; i < 6; i++) begin
      txn(vecs[i].op, vecs[i].addr, vecs[i].exp_addr, vecs[i].lat);
      if (vecs[i].op == 2'd1) exp_writes++;
      else exp_reads++;
      @(negedge clk); #1;
      chk("read_count", 32'(read_count), 32'(exp_reads));
      chk("write_count", 32'(write_count), 32'(exp_writes));
      chk("busy_after_resp", 32'(busy), 0);
    end

    // Response held off for 10 cycles while a second request waits.
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h0000_1010;
    #1;
    chk("stall_req_ready", 32'(req_ready), 1);
    sb.push_back('{op: 2'd0, addr: 32'h0000_1000, lat: 4});
    @(negedge clk);
    req_op = 2'd2; req_addr = 32'h0000_2000;
    wait_resp();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("stall_resp_valid", 32'(resp_valid), 1);
      chk("stall_resp_addr", resp_addr, 32'h0000_1000);
      chk("stall_req_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    chk("hs_cycle_req_ready", 32'(req_ready), 0);
    sb.push_back('{op: 2'd2, addr: 32'h0000_2000, lat: 4});
    @(negedge clk); #1;
    chk("after_hs_resp_valid", 32'(resp_valid), 0);
    chk("after_hs_req_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp();
    exp_reads += 2;

    // Evict pending blocks a same-block request but not a different block.
    @(negedge clk);
    evict_in_valid = 1'b1; evict_in_addr = 32'h0010_0000;
    #1;
    chk("evict_in_ready", 32'(evict_in_ready), 1);
    @(negedge clk);
    evict_in_valid = 1'b0;
    #1;
    chk("evict_valid", 32'(evict_valid), 1);
    chk("evict_addr", evict_addr, 32'h0010_0000);
    chk("evict_in_ready_full", 32'(evict_in_ready), 0);
    txn(2'd0, 32'h0020_0000, 32'h0020_0000, 4);
    exp_reads++;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h0010_0004;
    repeat (3) begin
      #1;
      chk("hazard_req_ready", 32'(req_ready), 0);
      chk("hazard_busy", 32'(busy), 0);
      @(negedge clk);
    end
    evict_ready = 1'b1;
    #1;
    chk("hazard_hold", 32'(req_ready), 0);
    chk("evict_count_pre", 32'(evict_count), 0);
    @(negedge clk);
    evict_ready = 1'b0;
    #1;
    chk("evict_released", 32'(evict_valid), 0);
    chk("evict_count", 32'(evict_count), 1);
    chk("hazard_cleared", 32'(req_ready), 1);
    sb.push_back('{op: 2'd0, addr: 32'h0010_0000, lat: 4});
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp();
    exp_reads++;

    // Request and evict accepted on the same edge, then both handshakes on one edge.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_addr = 32'h0000_3008;
    evict_in_valid = 1'b1; evict_in_addr = 32'h0000_4321;
    #1;
    chk("dual_req_ready", 32'(req_ready), 1);
    chk("dual_evict_in_ready", 32'(evict_in_ready), 1);
    sb.push_back('{op: 2'd2, addr: 32'h0000_3000, lat: 4});
    @(negedge clk);
    req_valid = 1'b0; evict_in_valid = 1'b0;
    wait_resp();
    exp_reads++;
    chk("dual_evict_valid", 32'(evict_valid), 1);
    chk("dual_evict_addr", evict_addr, 32'h0000_4300);
    evict_ready = 1'b1;
    @(negedge clk);
    evict_ready = 1'b0;
    #1;
    chk("dual_hs_busy", 32'(busy), 0);
    chk("dual_hs_evict_valid", 32'(evict_valid), 0);
    chk("dual_hs_evict_count", 32'(evict_count), 2);
    chk("total_read_count", 32'(read_count), 32'(exp_reads));
    chk("total_write_count", 32'(write_count), 32'(exp_writes));

    // Reset while BUSY with an evict pending.
    @(negedge clk);
    evict_in_valid = 1'b1; evict_in_addr = 32'h0000_5000;
    @(negedge clk);
    evict_in_valid = 1'b0;
    req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h0000_6000;
    #1;
    chk("pre_rst_req_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 0);
    chk("mid_rst_evict_valid", 32'(evict_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_resp_addr", resp_addr, 0);
    chk("mid_rst_evict_addr", evict_addr, 0);
    chk("mid_rst_read_count", 32'(read_count), 0);
    chk("mid_rst_write_count", 32'(write_count), 0);
    chk("mid_rst_evict_count", 32'(evict_count), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0;
    sb.delete();

    // Illegal op: handshake completes, nothing else happens.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd3; req_addr = 32'h0000_7000;
    #1;
    chk("op3_req_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) begin
      #1;
      chk("op3_resp_valid", 32'(resp_valid), 0);
      chk("op3_busy", 32'(busy), 0);
      @(negedge clk);
    end
    chk("op3_counts", {read_count, write_count} | 32'(evict_count), 0);
    txn(2'd0, 32'h0000_7010, 32'h0000_7000, 4);
    @(negedge clk); #1;
    chk("op3_then_read_count", 32'(read_count), 1);

    // Saturation on the 3-bit counter instance.
    m = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_req_valid = 1'b1; s_req_op = 2'd0;
      #1;
      chk("sat_read_count", 32'(s_read_count), 32'(sat3(m)));
      if (s_req_valid && s_req_ready) m++;
    end
    m = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_req_op = 2'd1;
      #1;
      chk("sat_write_count", 32'(s_write_count), 32'(sat3(m)));
      chk("sat_read_hold", 32'(s_read_count), 7);
      if (s_req_valid && s_req_ready && s_req_op == 2'd1) m++;
    end
    @(negedge clk);
    s_req_valid = 1'b0;
    m = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      s_evict_in_valid = 1'b1; s_evict_ready = 1'b1;
      #1;
      chk("sat_evict_count", 32'(s_evict_count), 32'(sat3(m)));
      if (s_evict_valid && s_evict_ready) m++;
    end
    @(negedge clk); #1;
    chk("sat_write_final", 32'(s_write_count), 7);
    chk("sat_evict_final", 32'(s_evict_count), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
